// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    Fetch,
    Drain
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, flush clears occupancy, head read straight from storage.
module fetch_fifo #(
  parameter int unsigned     Depth    = 2,
  parameter int unsigned     Width    = 64,
  parameter logic [Width-1:0] ResetVal = '0,
  localparam int unsigned    PtrW     = $clog2(Depth),
  localparam int unsigned    CntW     = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Storage is left untouched so the head simply holds its stale value.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
        count_d         = count_d + CntW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        count_d  = count_d - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: ResetVal};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight and feeds decode from a FIFO.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned      ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [24:0]       imm_field
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;

  logic [ADDR_W+31:0] fifo_head;
  logic [CntW-1:0]    fifo_count, count_nxt;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [ADDR_W-1:0]  redirect_aligned;
  logic               unused_redirect_lsb;

  assign redirect_aligned    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A redirect flushes the FIFO, so it also suppresses the pop and the push.
  assign pop  = ~fifo_empty & ~stall & ~redirect;
  assign push = (state_q == Fetch) & req_q & imem_ready & ~redirect & (~fifo_full | pop);

  always_comb begin
    count_nxt = fifo_count;
    if (push) count_nxt = count_nxt + CntW'(1);
    if (pop)  count_nxt = count_nxt - CntW'(1);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    unique case (state_q)
      Fetch: begin
        if (redirect) begin
          if (req_q && !imem_ready) begin
            // Memory still owes us a word: keep the request up and throw the word away later.
            state_d = Drain;
            rpc_d   = redirect_aligned;
          end else begin
            pc_d  = redirect_aligned;
            req_d = 1'b1;
          end
        end else if (!req_q || imem_ready) begin
          if (req_q) pc_d = pc_q + ADDR_W'(4);
          req_d = (count_nxt < CntW'(FIFO_DEPTH));
        end
      end
      Drain: begin
        if (redirect) rpc_d = redirect_aligned;
        if (imem_ready) begin
          state_d = Fetch;
          pc_d    = redirect ? redirect_aligned : rpc_q;
          req_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Fetch;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
    end
  end

  fetch_fifo #(
    .Depth    (FIFO_DEPTH),
    .Width    (32 + ADDR_W),
    .ResetVal ({NOP_INSTR, RESET_PC})
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  ({imem_rdata, pc_q}),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_head[ADDR_W+31:ADDR_W];
  assign instr_pc    = fifo_head[ADDR_W-1:0];
  assign pc_plus4    = fifo_head[ADDR_W-1:0] + ADDR_W'(4);
  assign imm_field   = fifo_head[ADDR_W+31:ADDR_W+7];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a wait-state programmable memory responder.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [24:0] imm_field;

  int n_tests = 0;
  int n_fail  = 0;
  int wait_cfg = 0;
  int wait_cnt = 0;
  bit force_ready = 1'b0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus4    (pc_plus4),
    .imm_field   (imm_field)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_for(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Memory responds wait_cfg cycles after a request is seen; force_ready injects a stray strobe.
  always @(negedge clk) begin
    if (force_ready) begin
      imem_ready = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
    end else if (rst_n && imem_req) begin
      if (wait_cnt >= wait_cfg) begin
        imem_ready = 1'b1;
        imem_rdata = instr_for(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ready = 1'b0;
        wait_cnt   = wait_cnt + 1;
      end
    end else begin
      imem_ready = 1'b0;
      wait_cnt   = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_head(input string name, input logic [31:0] pc);
    logic [31:0] w;
    w = instr_for(pc);
    check({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({name, "_pc"}, instr_pc, pc);
    check({name, "_instr"}, instr, w);
    check({name, "_imm"}, {7'd0, imm_field}, {7'd0, w[31:7]});
    check({name, "_pc4"}, pc_plus4, pc + 32'd4);
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          exp_valid;
    logic [31:0] exp_pc;
    bit          exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    // Zero-wait streaming, then a fresh reset followed by a 5-cycle stall and drain.
    vecs[0]  = '{1, 0, 0, 32'h0,  0, 32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0,  1, 32'h0};
    vecs[2]  = '{0, 0, 1, 32'h0,  1, 32'h4};
    vecs[3]  = '{0, 0, 1, 32'h4,  1, 32'h8};
    vecs[4]  = '{0, 0, 1, 32'h8,  1, 32'hC};
    vecs[5]  = '{1, 0, 0, 32'h0,  0, 32'h0};
    vecs[6]  = '{0, 1, 0, 32'h0,  1, 32'h0};
    vecs[7]  = '{0, 1, 1, 32'h0,  1, 32'h4};
    vecs[8]  = '{0, 1, 1, 32'h0,  0, 32'h8};
    vecs[9]  = '{0, 1, 1, 32'h0,  0, 32'h8};
    vecs[10] = '{0, 1, 1, 32'h0,  0, 32'h8};
    vecs[11] = '{0, 0, 1, 32'h4,  1, 32'h8};
    vecs[12] = '{0, 0, 1, 32'h8,  1, 32'hC};
    vecs[13] = '{0, 0, 1, 32'hC,  1, 32'h10};

    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);

    for (int i = 0; i < 14; i++) begin
      rst_n = ~vecs[i].rst;
      stall = vecs[i].stall;
      step();
      check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check_head($sformatf("v%0d", i), vecs[i].exp_pc);
    end
    stall = 1'b0;

    // Redirect while a 3-wait fetch is pending: response discarded, restart at 0x100.
    wait_cfg = 3;
    reset_dut();
    step();
    step();
    check("t3_pending_addr", imem_addr, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("t3_drain_req", {31'd0, imem_req}, 32'd1);
    check("t3_drain_addr", imem_addr, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      check("t3_no_stale", {31'd0, instr_valid}, 32'd0);
      step();
      if (imem_req && imem_addr == 32'h100) seen = 1'b1;
    end
    check("t3_addr_0x100", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 12 && !instr_valid; i++) step();
    check_head("t3_head", 32'h100);

    // Redirect to an unaligned PC coinciding with a zero-wait response.
    wait_cfg = 0;
    reset_dut();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    check("t4_addr", imem_addr, 32'h200);
    check("t4_empty", {31'd0, instr_valid}, 32'd0);
    step();
    check_head("t4_head", 32'h200);

    // Redirect with stall while the FIFO is full.
    reset_dut();
    stall = 1'b1;
    repeat (4) step();
    check("t5_full_req", {31'd0, imem_req}, 32'd0);
    check_head("t5_full_head", 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    check("t5_flush_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_new_addr", imem_addr, 32'h300);
    step();
    check_head("t5_head", 32'h300);
    stall = 1'b0;

    // PC wrap at the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    reset_dut();
    step();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check_head("wrap_head", 32'hFFFF_FFFC);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Reset pulse while the fetch at 0x40 is outstanding, then a stray imem_ready.
    wait_cfg = 3;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    reset_dut();
    step();
    redirect = 1'b0;
    check("t6_addr_40", imem_addr, 32'h40);
    step();
    rst_n = 1'b0;
    #1;
    check("t6_req_low", {31'd0, imem_req}, 32'd0);
    check("t6_addr_reset", imem_addr, 32'h0);
    force_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    force_ready = 1'b0;
    wait_cfg = 0;
    check("t6_stray_ignored", {31'd0, instr_valid}, 32'd0);
    check("t6_restart_addr", imem_addr, 32'h0);
    step();
    check_head("t6_head", 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
